// File: rtl/single_neuron_accum.sv
// Serial single-precision neuron pre-activation: bias + sum(x*w) over N_INPUTS beats.
// Contains the single_multiply (2-cycle) and single_add_1clk (1-cycle) cores it sequences.

module single_multiply (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] c
);
   logic               vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic               sign_p1_q, sign_p1_d, zero_p1_q, zero_p1_d;
   logic               inf_p1_q, inf_p1_d, nan_p1_q, nan_p1_d;
   logic signed [9:0]  exp_p1_q, exp_p1_d;
   logic [47:0]        prod_p1_q, prod_p1_d;
   logic [31:0]        c_p2_q, c_p2_d;
   logic [23:0]        ma, mb;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic signed [9:0]  e_n;
   logic [26:0]        m_n;

   function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] e,
                                              input logic [26:0] m);
      logic [24:0]       mant;
      logic signed [9:0] en;
      logic              up;
      up   = m[2] & (m[1] | m[0] | m[3]);
      mant = {1'b0, m[26:3]} + {24'b0, up};
      en   = e;
      if (mant[24]) begin
         mant = mant >> 1;
         en   = en + 10'sd1;
      end
      if (en >= 10'sd255)    round_pack = {sign, 8'hff, 23'h0};
      else if (en <= 10'sd0) round_pack = {sign, 31'h0};
      else                   round_pack = {sign, en[7:0], mant[22:0]};
   endfunction

   always_comb begin
      a_zero    = (a[30:23] == 8'h00);
      b_zero    = (b[30:23] == 8'h00);
      a_inf     = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
      b_inf     = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
      a_nan     = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
      b_nan     = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);
      ma        = {1'b1, a[22:0]};
      mb        = {1'b1, b[22:0]};
      vld_p1_d  = in_valid;
      sign_p1_d = a[31] ^ b[31];
      nan_p1_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      inf_p1_d  = a_inf | b_inf;
      zero_p1_d = a_zero | b_zero;
      prod_p1_d = {24'b0, ma} * {24'b0, mb};
      exp_p1_d  = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
   end

   // stage p1 -> p2: normalise the 48-bit product into 24 bits plus guard/round/sticky
   always_comb begin
      if (prod_p1_q[47]) begin
         m_n = {prod_p1_q[47:22], |prod_p1_q[21:0]};
         e_n = exp_p1_q + 10'sd1;
      end else begin
         m_n = {prod_p1_q[46:21], |prod_p1_q[20:0]};
         e_n = exp_p1_q;
      end
      vld_p2_d = vld_p1_q;
      if (nan_p1_q)       c_p2_d = 32'h7fc00000;
      else if (inf_p1_q)  c_p2_d = {sign_p1_q, 8'hff, 23'h0};
      else if (zero_p1_q) c_p2_d = {sign_p1_q, 31'h0};
      else                c_p2_d = round_pack(sign_p1_q, e_n, m_n);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
      end
      sign_p1_q <= sign_p1_d;
      zero_p1_q <= zero_p1_d;
      inf_p1_q  <= inf_p1_d;
      nan_p1_q  <= nan_p1_d;
      exp_p1_q  <= exp_p1_d;
      prod_p1_q <= prod_p1_d;
      c_p2_q    <= c_p2_d;
   end

   assign out_valid = vld_p2_q;
   assign c         = c_p2_q;
endmodule

module single_add_1clk (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] c
);
   logic              vld_q, vld_d;
   logic [31:0]       c_q, c_d;
   logic [31:0]       big, sml;
   logic [26:0]       mbig, msml, msh, diff, m;
   logic [27:0]       sum28;
   logic [4:0]        lz;
   logic signed [9:0] e;
   logic              a_inf, b_inf, a_nan, b_nan;

   function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] e_in,
                                              input logic [26:0] m_in);
      logic [24:0]       mant;
      logic signed [9:0] en;
      logic              up;
      up   = m_in[2] & (m_in[1] | m_in[0] | m_in[3]);
      mant = {1'b0, m_in[26:3]} + {24'b0, up};
      en   = e_in;
      if (mant[24]) begin
         mant = mant >> 1;
         en   = en + 10'sd1;
      end
      if (en >= 10'sd255)    round_pack = {sign, 8'hff, 23'h0};
      else if (en <= 10'sd0) round_pack = {sign, 31'h0};
      else                   round_pack = {sign, en[7:0], mant[22:0]};
   endfunction

   function automatic logic [26:0] shr_sticky(input logic [26:0] v, input logic [7:0] d);
      logic [26:0] tmp, mask;
      if (d >= 8'd27) begin
         shr_sticky = {26'b0, |v};
      end else begin
         tmp        = v >> d;
         mask       = (27'h1 << d) - 27'h1;
         shr_sticky = {tmp[26:1], tmp[0] | (|(v & mask))};
      end
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic found;
      found = 1'b0;
      lzc27 = 5'd0;
      for (int i = 26; i >= 0; i--) begin
         if (v[i])        found = 1'b1;
         else if (!found) lzc27 = lzc27 + 5'd1;
      end
   endfunction

   always_comb begin
      a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
      b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
      a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
      b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);
      // order by magnitude so the sign of the result is the sign of big
      if (b[30:0] > a[30:0]) begin
         big = b;
         sml = a;
      end else begin
         big = a;
         sml = b;
      end
      mbig  = (big[30:23] == 8'h00) ? 27'h0 : {1'b1, big[22:0], 3'b0};
      msml  = (sml[30:23] == 8'h00) ? 27'h0 : {1'b1, sml[22:0], 3'b0};
      msh   = shr_sticky(msml, big[30:23] - sml[30:23]);
      sum28 = {1'b0, mbig} + {1'b0, msh};
      diff  = mbig - msh;
      lz    = lzc27(diff);
      if (big[31] == sml[31]) begin
         if (sum28[27]) begin
            m = {sum28[27:2], sum28[1] | sum28[0]};
            e = $signed({2'b0, big[30:23]}) + 10'sd1;
         end else begin
            m = sum28[26:0];
            e = $signed({2'b0, big[30:23]});
         end
      end else begin
         m = diff << lz;
         e = $signed({2'b0, big[30:23]}) - $signed({5'b0, lz});
      end
      vld_d = in_valid;
      if (a_nan | b_nan | (a_inf & b_inf & (a[31] != b[31]))) c_d = 32'h7fc00000;
      else if (a_inf)                                          c_d = a;
      else if (b_inf)                                          c_d = b;
      else if ((big[31] != sml[31]) && (diff == 27'h0))        c_d = 32'h0;
      else                                                     c_d = round_pack(big[31], e, m);
   end

   always_ff @(posedge clk) begin
      if (!rstn) vld_q <= 1'b0;
      else       vld_q <= vld_d;
      c_q <= c_d;
   end

   assign out_valid = vld_q;
   assign c         = c_q;
endmodule

module single_neuron_accum #(
   parameter int N_INPUTS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   input  logic [31:0] w,
   input  logic [31:0] bias,
   output logic        out_valid,
   output logic [31:0] c
);
   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

   typedef enum logic [1:0] {S_READY, S_MUL, S_ADD, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      acc_q, acc_d, c_q, c_d;
   logic             beat, core_rstn;
   logic             mul_in_vld, mul_out_vld, add_in_vld, add_out_vld;
   logic [31:0]      prod, prod_flush, sum;

   assign core_rstn  = ~rst;
   assign beat       = in_valid && in_ready;
   assign prod_flush = (prod[30:23] == 8'h00) ? 32'h0 : prod;

   // x/w go straight into the multiplier's input stage on the accept edge
   single_multiply u_mul (
      .clk       (clk),
      .rstn      (core_rstn),
      .in_valid  (mul_in_vld),
      .a         (x),
      .b         (w),
      .out_valid (mul_out_vld),
      .c         (prod)
   );

   single_add_1clk u_add (
      .clk       (clk),
      .rstn      (core_rstn),
      .in_valid  (add_in_vld),
      .a         (acc_q),
      .b         (prod_flush),
      .out_valid (add_out_vld),
      .c         (sum)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_READY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_READY: if (beat)        state_d = S_MUL;
         S_MUL:   if (mul_out_vld) state_d = S_ADD;
         S_ADD:   if (add_out_vld) state_d = (cnt_q == CNT_LAST) ? S_DONE : S_READY;
         default:                  state_d = S_READY;
      endcase
   end

   always_comb begin
      in_ready   = (state_q == S_READY) && !rst;
      out_valid  = (state_q == S_DONE);
      mul_in_vld = beat;
      add_in_vld = (state_q == S_MUL) && mul_out_vld && !rst;
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      c_d   = c_q;
      if (beat && (cnt_q == '0)) acc_d = bias;
      if ((state_q == S_ADD) && add_out_vld) begin
         acc_d = sum;
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            c_d   = sum;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= 32'h0;
         cnt_q <= '0;
         c_q   <= 32'h0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         c_q   <= c_d;
      end
   end

   assign c = c_q;
endmodule

// File: doc/single_neuron_accum.md
# single_neuron_accum

Serial single-precision neuron pre-activation unit: accepts a vector of N_INPUTS (x, w) operand pairs plus a bias and produces bias + Σ x·w as an IEEE-754 single. It sits directly upstream of the sigmoid activation stage. Its one-cycle `out_valid`/`c` pair drives that stage's `in_valid`/`a` inputs directly. Arithmetic uses the team's `single_multiply` and `single_add_1clk` cores. This block owns sequencing, hazard avoidance and vector framing.

## Interface
- N_INPUTS, default 8, number of products per vector (≥1); counter width $clog2(N_INPUTS), minimum 1.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset. Cores receive rstn = ~rst.
- in_valid  in  1  x/w/bias valid this cycle.
- in_ready  out  1  block accepts a pair this cycle. A beat is consumed only when in_valid && in_ready.
- x  in  32  input activation, single precision.
- w  in  32  weight, single precision.
- bias  in  32  sampled only on the first beat of a vector; ignored otherwise.
- out_valid  out  1  one-cycle pulse, result on c.
- c  out  32  accumulated result; holds its value until the next out_valid.

## Operation
- Registers:
  - acc[31:0]
  - cnt (beat index)
  - state
  - c_reg
- States and transitions:
  - S_READY: in_ready=1. On beat:
    - latch x,w into operand regs.
    - if cnt==0, acc ← bias.
    - pulse multiplier in_valid for exactly 1 cycle.
    - → S_MUL.
  - S_MUL: in_ready=0. Wait for multiplier out_valid, then:
    - latch product. If product[30:23]==0, the product is flushed to +0 (denormal/zero flush, matches the activation stage).
    - pulse adder in_valid with a=acc, b=product.
    - → S_ADD.
  - S_ADD: in_ready=0. Wait for adder out_valid, then acc ← sum.
    - if cnt==N_INPUTS-1: cnt ← 0, c_reg ← sum, → S_DONE.
    - else cnt ← cnt+1, → S_READY.
  - S_DONE: out_valid=1 for this single cycle, in_ready=0 → S_READY.
- Only one multiply and one add are in flight at any time, so there is no read-after-write hazard on acc.
- A core out_valid arriving in a state that does not expect it is ignored.
- in_valid while in_ready=0: no effect; no operand, bias or count change.
- No overflow/NaN special handling beyond what the cores produce; results pass through unmodified.

## Timing
- Reset values:
  - state=S_READY
  - in_ready=1 (first cycle after rst deasserts)
  - out_valid=0
  - c=0
  - acc=0
  - cnt=0
- Core pulses are deasserted during reset.
- Per-beat occupancy: 1 (accept) + L_MUL + L_ADD cycles, where L_MUL and L_ADD are the cores' valid-to-valid latencies. L_ADD=1 for single_add_1clk.
- in_ready reasserts the cycle after adder out_valid for non-final beats. For the final beat it reasserts the cycle after the S_DONE pulse.
- Vector latency, final accept to out_valid: L_MUL + L_ADD + 1 cycles.
- Back-to-back vectors: the next vector's first beat can be accepted the cycle after out_valid. That beat reloads acc from bias, so nothing carries over between vectors.
- Reset mid-vector (any state):
  - everything returns to reset values next cycle.
  - partial sum discarded.
  - late core outputs are suppressed because the cores are reset too.
- N_INPUTS=1: every beat produces one out_valid with value bias + x·w.

## Test plan
- N=4, bias=0x3f000000 (0.5), four beats x=0x3f800000, w=0x40000000 → exactly one out_valid, c=0x41080000 (8.5).
- N=4, bias=0, four beats x=0xbf800000, w=0x3f800000 → c=0xc0800000 (-4.0).
- Denormal flush: N=4, bias=0x3f000000, x=0x00400000, w=0x3f800000 on all beats → c=0x3f000000.
- Stall: hold in_valid=1 with changing x while in_ready=0 → only values present on in_ready cycles are consumed. Check the beat count and the 8.5 result from test 1.
- Reset mid-vector: two beats of test-1 data, rst for 1 cycle, then the full test-1 vector → single out_valid, c=0x41080000. No out_valid from the aborted vector. c=0 right after reset.
- Back-to-back: test-1 vector followed immediately by test-2 vector (first beat in the cycle after out_valid) → two pulses, c=0x41080000 then 0xc0800000. Checker also confirms the measured latency equals L_MUL+L_ADD+1.
